vga_seg_clock_renderer: RTL and testbench
=========================================

Name: vga_seg_clock_renderer

Overview:
Parametrised successor to the fixed six-digit VGA clock overlay. It renders NUM_DIGITS active-low seven-segment patterns plus optional colon separators on a 640x480 raster. Positions, segment size and colours are set by parameters. The segment bus is snapshotted once per frame so digits never tear, and the colons blink on a frame counter. The output is a 2-pixel pipelined RGB stream with matching delayed syncs. The block sits between vga640x480 (x/y/sync source) and the board VGA pins.

Parameters:
NUM_DIGITS, 6, number of digits, 1..8
X0, 60, left edge of digit 0 (pixels)
Y0, 185, top edge of all digits (pixels)
SEG_T, 15, segment thickness (pixels)
SEG_L, 30, segment length (pixels)
DIGIT_PITCH, 75, origin-to-origin spacing of adjacent digits
COLON_MASK, 8'b0000_1010, bit d set = colon after digit d
COLON_PITCH, 60, extra x shift applied to all digits after each colon
COLON_OFS, 30, gap from a digit box's right edge to its colon column
BLINK_FRAMES, 30, frames per colon blink half-period, >=1
FG_RGB, 12'hF40, lit colour {R,G,B} 4 bits each
BG_RGB, 12'h800, active-area background colour

Ports:
i_clk  in  1  system clock (100 MHz)
i_rst  in  1  synchronous active-high reset
i_pix_stb  in  1  pixel strobe; all pixel-rate state advances only when high
i_x  in  10  current pixel x from timing generator
i_y  in  9  current pixel y from timing generator
i_hs  in  1  horizontal sync from timing generator
i_vs  in  1  vertical sync from timing generator
i_active  in  1  high inside the 640x480 visible area
i_frame  in  1  one-strobe pulse at the end of each frame
i_seg  in  NUM_DIGITS*7  active-low segments; digit d occupies [7d+6:7d]; bit 6 = seg0 (top) ... bit 0 = seg6 (middle)
i_colon_blink  in  1  1 = colons blink, 0 = colons steady on
o_hs  out  1  i_hs delayed 2 strobes
o_vs  out  1  i_vs delayed 2 strobes
o_r  out  4  red
o_g  out  4  green
o_b  out  4  blue

Behaviour:
- Reset values: o_r/o_g/o_b = 0; o_hs = o_vs = 1 (idle); pipeline valid/active = 0; seg shadow = all ones (all segments off); blink counter = 0; colon phase = 1 (visible).
- Snapshot: on a cycle with i_pix_stb & i_frame, shadow <= i_seg. The value present on that cycle wins. i_seg changes at any other time have no visible effect until the next frame.
- Blink: on each i_pix_stb & i_frame, the counter increments. At BLINK_FRAMES-1 the counter wraps to 0 and the phase toggles. Colons are lit when (phase | ~i_colon_blink). The counter runs regardless of i_colon_blink.
- Geometry: digit d origin ox(d) = X0 + d*DIGIT_PITCH + COLON_PITCH*(count of COLON_MASK bits below d); oy = Y0. All boxes are half-open [lo,hi). With rx = x-ox and ry = y-oy:
  - seg0: rx in [T,T+L), ry in [0,T)
  - seg1: rx in [T+L,2T+L), ry in [T,T+L)
  - seg2: rx in [T+L,2T+L), ry in [T+L,T+2L)
  - seg3: rx in [T,T+L), ry in [T+2L,2T+2L)
  - seg4: rx in [0,T), ry in [T+L,T+2L)
  - seg5: rx in [0,T), ry in [T,T+L)
  - seg6: rx in [T,T+L), ry in [T+L-T/2, T+L+T/2)
  - Colon after digit d: cx = ox(d)+2T+L+COLON_OFS; x in [cx,cx+T); dots at ry in [T,2T) and [2L,2L+T).
- Coordinate arithmetic is done at 11 bits unsigned, so there is no wrap. Geometry exceeding 640x480 is simply clipped.
- Pipeline, advancing only on i_pix_stb:
  - Stage 1 registers per-segment hit bits, colon hit and i_active.
  - Stage 2 ANDs hits with ~shadow and the colon-lit signal, then registers the colour.
  - Latency from x/y to colour is exactly 2 strobes. hs/vs are delayed through the same two stages.
- Colour: stage-2 active = 0 gives 0; lit gives FG_RGB; otherwise BG_RGB.
- Without i_pix_stb, all registers hold their values.
- Reset mid-frame: on the next clock all outputs take reset values. Rendering resumes with segments off until the first i_frame snapshot.

Test Plan:
- Reset then release with i_seg=all ones and i_active=1 everywhere -> o_{r,g,b}=0 during the first two strobes, then BG 8,0,0 at every visible pixel (colons aside).
- i_seg digit0=7'b0000001 ("0" pattern), i_frame pulse, scan row y=190 -> FG F,4,0 for x in [75,105) appearing 2 strobes after x=75; BG at x=74 and x=105.
- Change i_seg mid-frame without i_frame -> output unchanged for the rest of the frame; after the next i_frame pulse the new pattern appears.
- i_colon_blink=1, BLINK_FRAMES=2 -> pixel (230,205) lit for frames 0-1, background for frames 2-3, lit again for frame 4. Set i_colon_blink=0 -> lit every frame.
- Toggle i_hs/i_vs -> o_hs/o_vs follow exactly 2 strobes later. With i_pix_stb held low for 10 clocks, all outputs are frozen.
- Assert i_rst mid-line -> next clock outputs are 0, o_hs=o_vs=1, shadow cleared (no segments drawn until the next i_frame).

Source files
------------

// File: rtl/vga_seg_clock_renderer.sv
// vga_seg_clock_renderer
// Draws NUM_DIGITS active-low seven-segment digits and optional colons over
// a 640x480 raster. The segment bus is captured once per frame, colons blink
// on a frame counter, and colour plus syncs leave through a 2-strobe pipeline.
module vga_seg_clock_renderer #(
  parameter int unsigned NUM_DIGITS   = 6,
  parameter int unsigned X0           = 60,
  parameter int unsigned Y0           = 185,
  parameter int unsigned SEG_T        = 15,
  parameter int unsigned SEG_L        = 30,
  parameter int unsigned DIGIT_PITCH  = 75,
  parameter logic [7:0]  COLON_MASK   = 8'b0000_1010,
  parameter int unsigned COLON_PITCH  = 60,
  parameter int unsigned COLON_OFS    = 30,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter logic [11:0] FG_RGB       = 12'hF40,
  parameter logic [11:0] BG_RGB       = 12'h800
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_pix_stb,
  input  logic [9:0]              i_x,
  input  logic [8:0]              i_y,
  input  logic                    i_hs,
  input  logic                    i_vs,
  input  logic                    i_active,
  input  logic                    i_frame,
  input  logic [NUM_DIGITS*7-1:0] i_seg,
  input  logic                    i_colon_blink,
  output logic                    o_hs,
  output logic                    o_vs,
  output logic [3:0]              o_r,
  output logic [3:0]              o_g,
  output logic [3:0]              o_b
);

  localparam int unsigned NSEG  = NUM_DIGITS * 7;
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  // Number of colons that sit to the left of digit d (each one shifts d right).
  function automatic int unsigned colons_below(input int unsigned d);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < d; i++) begin
      n = n + 32'(COLON_MASK[i[2:0]]);
    end
    return n;
  endfunction

  // Half-open rectangle test on 11-bit unsigned coordinates.
  function automatic logic in_box(input logic [10:0] px, input logic [10:0] py,
                                  input logic [10:0] xlo, input logic [10:0] xhi,
                                  input logic [10:0] ylo, input logic [10:0] yhi);
    return (px >= xlo) && (px < xhi) && (py >= ylo) && (py < yhi);
  endfunction

  logic [10:0]           w_x;
  logic [10:0]           w_y;
  logic [NSEG-1:0]       w_seg_hit;
  logic [NUM_DIGITS-1:0] w_colon_hit;
  logic                  w_colon_lit;
  logic                  w_lit;
  logic [11:0]           w_rgb;

  logic [NSEG-1:0]  r_shadow;
  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_phase;
  logic [NSEG-1:0]  r_s1_hit;
  logic             r_s1_colon;
  logic             r_s1_active;
  logic             r_s1_hs;
  logic             r_s1_vs;
  logic [11:0]      r_rgb;
  logic             r_hs;
  logic             r_vs;

  assign w_x = {1'b0, i_x};
  assign w_y = {2'b00, i_y};

  // Per-digit segment and colon hit detection against constant box edges.
  // Hit bit order matches i_seg: bit 7d+6 is seg0 ... bit 7d+0 is seg6.
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    localparam int unsigned OX = X0 + d * DIGIT_PITCH + COLON_PITCH * colons_below(d);
    localparam logic [10:0] XA  = 11'(OX);
    localparam logic [10:0] XB  = 11'(OX + SEG_T);
    localparam logic [10:0] XC  = 11'(OX + SEG_T + SEG_L);
    localparam logic [10:0] XD  = 11'(OX + 2 * SEG_T + SEG_L);
    localparam logic [10:0] YA  = 11'(Y0);
    localparam logic [10:0] YB  = 11'(Y0 + SEG_T);
    localparam logic [10:0] YC  = 11'(Y0 + SEG_T + SEG_L);
    localparam logic [10:0] YD  = 11'(Y0 + SEG_T + 2 * SEG_L);
    localparam logic [10:0] YE  = 11'(Y0 + 2 * SEG_T + 2 * SEG_L);
    localparam logic [10:0] YM0 = 11'(Y0 + SEG_T + SEG_L - SEG_T / 2);
    localparam logic [10:0] YM1 = 11'(Y0 + SEG_T + SEG_L + SEG_T / 2);

    assign w_seg_hit[7*d+6] = in_box(w_x, w_y, XB, XC, YA,  YB);   // seg0 top
    assign w_seg_hit[7*d+5] = in_box(w_x, w_y, XC, XD, YB,  YC);   // seg1 upper right
    assign w_seg_hit[7*d+4] = in_box(w_x, w_y, XC, XD, YC,  YD);   // seg2 lower right
    assign w_seg_hit[7*d+3] = in_box(w_x, w_y, XB, XC, YD,  YE);   // seg3 bottom
    assign w_seg_hit[7*d+2] = in_box(w_x, w_y, XA, XB, YC,  YD);   // seg4 lower left
    assign w_seg_hit[7*d+1] = in_box(w_x, w_y, XA, XB, YB,  YC);   // seg5 upper left
    assign w_seg_hit[7*d+0] = in_box(w_x, w_y, XB, XC, YM0, YM1);  // seg6 middle

    if (COLON_MASK[d]) begin : g_colon
      localparam int unsigned CX  = OX + 2 * SEG_T + SEG_L + COLON_OFS;
      localparam logic [10:0] CXA = 11'(CX);
      localparam logic [10:0] CXB = 11'(CX + SEG_T);
      localparam logic [10:0] CY0 = 11'(Y0 + SEG_T);
      localparam logic [10:0] CY1 = 11'(Y0 + 2 * SEG_T);
      localparam logic [10:0] CY2 = 11'(Y0 + 2 * SEG_L);
      localparam logic [10:0] CY3 = 11'(Y0 + 2 * SEG_L + SEG_T);
      assign w_colon_hit[d] = in_box(w_x, w_y, CXA, CXB, CY0, CY1) |
                              in_box(w_x, w_y, CXA, CXB, CY2, CY3);
    end else begin : g_no_colon
      assign w_colon_hit[d] = 1'b0;
    end
  end

  // Frame-rate state: segment shadow snapshot and colon blink counter/phase.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow    <= {NSEG{1'b1}};
      r_blink_cnt <= {CNT_W{1'b0}};
      r_phase     <= 1'b1;
    end else if (i_pix_stb && i_frame) begin
      r_shadow <= i_seg;
      if (r_blink_cnt == CNT_LAST) begin
        r_blink_cnt <= {CNT_W{1'b0}};
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + CNT_W'(1);
      end
    end
  end

  // Stage 1: register geometry hits, active flag and syncs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_hit    <= {NSEG{1'b0}};
      r_s1_colon  <= 1'b0;
      r_s1_active <= 1'b0;
      r_s1_hs     <= 1'b1;
      r_s1_vs     <= 1'b1;
    end else if (i_pix_stb) begin
      r_s1_hit    <= w_seg_hit;
      r_s1_colon  <= |w_colon_hit;
      r_s1_active <= i_active;
      r_s1_hs     <= i_hs;
      r_s1_vs     <= i_vs;
    end
  end

  // Stage 2 colour decision: lit segments or lit colon give FG, else BG,
  // blanked outside the visible area.
  always_comb begin
    w_colon_lit = r_phase | ~i_colon_blink;
    w_lit       = (|(r_s1_hit & ~r_shadow)) | (r_s1_colon & w_colon_lit);
    w_rgb       = 12'h000;
    if (!r_s1_active) begin
      w_rgb = 12'h000;
    end else if (w_lit) begin
      w_rgb = FG_RGB;
    end else begin
      w_rgb = BG_RGB;
    end
  end

  // Stage 2: register colour and the twice-delayed syncs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rgb <= 12'h000;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
    end else if (i_pix_stb) begin
      r_rgb <= w_rgb;
      r_hs  <= r_s1_hs;
      r_vs  <= r_s1_vs;
    end
  end

  assign o_r  = r_rgb[11:8];
  assign o_g  = r_rgb[7:4];
  assign o_b  = r_rgb[3:0];
  assign o_hs = r_hs;
  assign o_vs = r_vs;

endmodule

// File: tb/tb_vga_seg_clock_renderer.sv
// Scoreboard bench for vga_seg_clock_renderer: the driver pushes the
// hand-computed colour/sync for each strobed pixel, the monitor pops and
// compares it when that pixel reaches the outputs.
module tb_vga_seg_clock_renderer;

  localparam int ND = 6;
  localparam logic [11:0] FG = 12'hF40;
  localparam logic [11:0] BG = 12'h800;
  localparam logic [11:0] BK = 12'h000;

  logic          clk = 1'b0;
  logic          i_rst, i_pix_stb, i_hs, i_vs, i_active, i_frame, i_colon_blink;
  logic [9:0]    i_x;
  logic [8:0]    i_y;
  logic [ND*7-1:0] i_seg;
  logic          o_hs, o_vs;
  logic [3:0]    o_r, o_g, o_b;

  typedef struct {
    int          at;
    int          id;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int drv_n = 0;
  int mon_n = 0;
  int id_n  = 0;

  always #5 clk = ~clk;

  vga_seg_clock_renderer #(.NUM_DIGITS(ND), .BLINK_FRAMES(2)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb), .i_x(i_x), .i_y(i_y),
    .i_hs(i_hs), .i_vs(i_vs), .i_active(i_active), .i_frame(i_frame),
    .i_seg(i_seg), .i_colon_blink(i_colon_blink),
    .o_hs(o_hs), .o_vs(o_vs), .o_r(o_r), .o_g(o_g), .o_b(o_b)
  );

  // One strobed pixel; expected output is queued for the monitor.
  task automatic pix(input int x, input int y, input logic act, input logic hs,
                     input logic vs, input logic frm, input logic [11:0] exp,
                     input logic chk);
    exp_t e;
    @(negedge clk);
    i_pix_stb = 1'b1; i_x = 10'(x); i_y = 9'(y); i_active = act;
    i_hs = hs; i_vs = vs; i_frame = frm;
    drv_n++; id_n++;
    if (chk) begin
      e.at = drv_n; e.id = id_n; e.rgb = exp; e.hs = hs; e.vs = vs;
      q.push_back(e);
    end
    @(posedge clk);
    #2;
    i_pix_stb = 1'b0; i_frame = 1'b0;
  endtask

  task automatic check_now(input string nm, input logic [11:0] rgb,
                           input logic hs, input logic vs);
    total++;
    if ({o_r, o_g, o_b} !== rgb || o_hs !== hs || o_vs !== vs) begin
      bad++;
      $display("FAIL %s: got rgb=%h hs=%b vs=%b, want rgb=%h hs=%b vs=%b",
               nm, {o_r, o_g, o_b}, o_hs, o_vs, rgb, hs, vs);
    end
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    i_rst = 1'b1; i_pix_stb = 1'b0; i_frame = 1'b0;
    q.delete();
    @(posedge clk);
    #2;
    check_now(nm, BK, 1'b1, 1'b1);
    @(negedge clk);
    i_rst = 1'b0;
  endtask

  // Monitor: output after strobe m belongs to the pixel captured at strobe m-1.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (i_pix_stb && !i_rst) begin
        mon_n++;
        #1;
        if (q.size() > 0 && q[0].at < mon_n) begin
          e = q.pop_front();
          total++;
          if (e.at != mon_n - 1 || {o_r, o_g, o_b} !== e.rgb ||
              o_hs !== e.hs || o_vs !== e.vs) begin
            bad++;
            $display("FAIL pix%0d: got rgb=%h hs=%b vs=%b at strobe %0d, want rgb=%h hs=%b vs=%b for strobe %0d",
                     e.id, {o_r, o_g, o_b}, o_hs, o_vs, mon_n, e.rgb, e.hs, e.vs, e.at + 1);
          end
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst = 1'b1; i_pix_stb = 1'b0; i_x = 10'd0; i_y = 9'd0;
    i_hs = 1'b1; i_vs = 1'b1; i_active = 1'b0; i_frame = 1'b0;
    i_seg = '1; i_colon_blink = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_now("reset", BK, 1'b1, 1'b1);
    @(negedge clk);
    i_rst = 1'b0;

    // Segments off after reset: background only.
    pix(300, 300, 1'b1, 1'b1, 1'b1, 1'b0, BG, 1'b1);
    check_now("prime0", BK, 1'b1, 1'b1);
    pix(74, 190, 1'b1, 1'b1, 1'b1, 1'b0, BG, 1'b1);
    pix(75, 190, 1'b1, 1'b1, 1'b1, 1'b0, BG, 1'b1);
    pix(104, 190, 1'b1, 1'b1, 1'b1, 1'b0, BG, 1'b1);
    pix(105, 190, 1'b1, 1'b1, 1'b1, 1'b0, BG, 1'b1);

    // Digit 0 shows "0" after a frame snapshot.
    i_seg[6:0] = 7'b0000001;
    pix(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, BK, 1'b1);
    pix(74, 190, 1'b1, 1'b1, 1'b1, 1'b0, BG, 1'b1);
    pix(75, 190, 1'b1, 1'b1, 1'b1, 1'b0, FG, 1'b1);
    pix(104, 190, 1'b1, 1'b1, 1'b1, 1'b0, FG, 1'b1);
    pix(105, 190, 1'b1, 1'b1, 1'b1, 1'b0, BG, 1'b1);
    pix(80, 230, 1'b1, 1'b1, 1'b1, 1'b0, BG, 1'b1);
    pix(65, 240, 1'b1, 1'b1, 1'b1, 1'b0, FG, 1'b1);
    pix(90, 259, 1'b1, 1'b1, 1'b1, 1'b0, BG, 1'b1);
    pix(90, 260, 1'b1, 1'b1, 1'b1, 1'b0, FG, 1'b1);
    pix(150, 190, 1'b1, 1'b1, 1'b1, 1'b0, BG, 1'b1);
    pix(230, 205, 1'b1, 1'b1, 1'b1, 1'b0, FG, 1'b1);

    // Sync delay, then a 10-clock freeze with junk on every input.
    pix(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, BK, 1'b1);
    pix(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, BK, 1'b1);
    pix(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, BK, 1'b1);
    pix(75, 190, 1'b1, 1'b0, 1'b1, 1'b0, FG, 1'b1);
    pix(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, BK, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      i_x = 10'($urandom_range(0, 639)); i_y = 9'($urandom_range(0, 479));
      i_active = 1'b1; i_hs = i[0]; i_vs = ~i[0]; i_frame = 1'b1; i_seg = '1;
      @(posedge clk);
      #2;
      check_now("freeze", FG, 1'b0, 1'b1);
    end
    i_seg = '1; i_seg[6:0] = 7'b0000001; i_frame = 1'b0;
    pix(80, 190, 1'b1, 1'b1, 1'b1, 1'b0, FG, 1'b1);

    // Mid-frame bus change is invisible until the next snapshot.
    i_seg[6:0] = 7'b1001111;
    pix(80, 190, 1'b1, 1'b1, 1'b1, 1'b0, FG, 1'b1);
    pix(65, 240, 1'b1, 1'b1, 1'b1, 1'b0, FG, 1'b1);
    pix(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, BK, 1'b1);
    pix(80, 190, 1'b1, 1'b1, 1'b1, 1'b0, BG, 1'b1);
    pix(65, 240, 1'b1, 1'b1, 1'b1, 1'b0, BG, 1'b1);
    pix(110, 210, 1'b1, 1'b1, 1'b1, 1'b0, FG, 1'b1);

    // Reset mid-line clears outputs and the shadow.
    pix(110, 210, 1'b1, 1'b0, 1'b0, 1'b0, FG, 1'b1);
    pix(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, BK, 1'b0);
    do_reset("midrst");
    pix(110, 210, 1'b1, 1'b1, 1'b1, 1'b0, BG, 1'b1);
    pix(80, 190, 1'b1, 1'b1, 1'b1, 1'b0, BG, 1'b1);

    // Colon blink with a 2-frame half-period, starting fresh after reset.
    pix(230, 205, 1'b1, 1'b1, 1'b1, 1'b0, FG, 1'b1);   // frame 0
    pix(150, 205, 1'b1, 1'b1, 1'b1, 1'b0, BG, 1'b1);
    pix(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, BK, 1'b1);
    pix(230, 205, 1'b1, 1'b1, 1'b1, 1'b0, FG, 1'b1);   // frame 1
    pix(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, BK, 1'b1);
    pix(230, 205, 1'b1, 1'b1, 1'b1, 1'b0, BG, 1'b1);   // frame 2
    pix(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, BK, 1'b1);
    pix(230, 205, 1'b1, 1'b1, 1'b1, 1'b0, BG, 1'b1);   // frame 3
    pix(435, 250, 1'b1, 1'b1, 1'b1, 1'b0, BG, 1'b1);
    pix(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, BK, 1'b1);
    pix(230, 205, 1'b1, 1'b1, 1'b1, 1'b0, FG, 1'b1);   // frame 4
    pix(435, 250, 1'b1, 1'b1, 1'b1, 1'b0, FG, 1'b1);
    pix(239, 205, 1'b1, 1'b1, 1'b1, 1'b0, FG, 1'b1);
    pix(240, 205, 1'b1, 1'b1, 1'b1, 1'b0, BG, 1'b1);
    pix(230, 215, 1'b1, 1'b1, 1'b1, 1'b0, BG, 1'b1);
    pix(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, BK, 1'b1);
    pix(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, BK, 1'b1);
    pix(230, 205, 1'b1, 1'b1, 1'b1, 1'b0, BG, 1'b1);   // frame 6, phase off
    pix(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, BK, 1'b1);
    i_colon_blink = 1'b0;
    pix(230, 205, 1'b1, 1'b1, 1'b1, 1'b0, FG, 1'b1);   // steady on
    pix(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, BK, 1'b1);
    pix(230, 205, 1'b1, 1'b1, 1'b1, 1'b0, FG, 1'b1);

    // Drain the pipeline and make sure every queued pixel was checked.
    pix(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, BK, 1'b1);
    pix(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, BK, 1'b0);
    repeat (3) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked pixels, want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
